seven_segment_bcd_display: RTL and testbench

//  Parametrised successor of the two-digit divide/modulo segment decoder. Converts an unsigned

---
 rtl/seven_segment_bcd_display_pkg.sv | 35 +++
 rtl/seven_segment_bcd_display_if.sv | 23 ++
 rtl/seven_segment_bcd_display_glyph.sv | 33 +++
 rtl/seven_segment_bcd_display.sv | 161 ++++++++++++++++
 tb/tb_seven_segment_bcd_display.sv | 250 +++++++++++++++++++++++++
 5 files changed

// File: rtl/seven_segment_bcd_display_pkg.sv
// Shared glyphs, FSM encoding and helpers for the BCD segment display.
// Pure declarations; no latency or backpressure of its own.
package seg7_pkg;

  // Active-high glyphs, bit order {g,f,e,d,c,b,a}
  localparam logic [6:0] SEG_0     = 7'b0111111;
  localparam logic [6:0] SEG_1     = 7'b0000110;
  localparam logic [6:0] SEG_2     = 7'b1011011;
  localparam logic [6:0] SEG_3     = 7'b1001111;
  localparam logic [6:0] SEG_4     = 7'b1100110;
  localparam logic [6:0] SEG_5     = 7'b1101101;
  localparam logic [6:0] SEG_6     = 7'b1111101;
  localparam logic [6:0] SEG_7     = 7'b0000111;
  localparam logic [6:0] SEG_8     = 7'b1111111;
  localparam logic [6:0] SEG_9     = 7'b1101111;
  localparam logic [6:0] SEG_BLANK = 7'b0000000;
  localparam logic [6:0] SEG_DASH  = 7'b1000000;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SHIFT  = 2'd1,
    UPDATE = 2'd2
  } state_e;

  // Largest value representable in the given number of decimal digits.
  function automatic logic [63:0] max_value(input int digits);
    logic [63:0] p;
    p = 64'd1;
    for (int i = 0; i < digits; i++) begin
      p = p * 64'd10;
    end
    return p - 64'd1;
  endfunction

endpackage

// File: rtl/seven_segment_bcd_display_if.sv
// Load/busy handshake and display outputs of the BCD segment display.
// master drives the request side, slave is the display block.
interface seven_segment_bcd_display_if #(
  parameter int WIDTH  = 7,
  parameter int DIGITS = 2
);
  logic [WIDTH-1:0]    i_Value;
  logic                i_Load;
  logic                o_Busy;
  logic                o_Done;
  logic                o_Overflow;
  logic [7*DIGITS-1:0] o_Segments;

  modport master (
    output i_Value, i_Load,
    input  o_Busy, o_Done, o_Overflow, o_Segments
  );

  modport slave (
    input  i_Value, i_Load,
    output o_Busy, o_Done, o_Overflow, o_Segments
  );
endinterface

// File: rtl/seven_segment_bcd_display_glyph.sv
// One decimal digit to active-high 7-segment pattern; dash wins over blank.
// Combinational, zero latency, no handshake.
module seg7_glyph
  import seg7_pkg::*;
(
  input  logic [3:0] i_Digit,
  input  logic       i_Blank,
  input  logic       i_Dash,
  output logic [6:0] o_Seg
);

  always_comb begin
    o_Seg = SEG_BLANK;
    if (i_Dash) begin
      o_Seg = SEG_DASH;
    end else if (!i_Blank) begin
      case (i_Digit)
        4'd0:    o_Seg = SEG_0;
        4'd1:    o_Seg = SEG_1;
        4'd2:    o_Seg = SEG_2;
        4'd3:    o_Seg = SEG_3;
        4'd4:    o_Seg = SEG_4;
        4'd5:    o_Seg = SEG_5;
        4'd6:    o_Seg = SEG_6;
        4'd7:    o_Seg = SEG_7;
        4'd8:    o_Seg = SEG_8;
        4'd9:    o_Seg = SEG_9;
        default: o_Seg = SEG_BLANK;
      endcase
    end
  end

endmodule

// File: rtl/seven_segment_bcd_display.sv
// Binary to DIGITS x 7-segment via sequential double-dabble; WIDTH+1 cycles accept-to-display.
// i_Load is ignored while o_Busy is high; segments hold their last value between conversions.
module seven_segment_bcd_display
  import seg7_pkg::*;
#(
  parameter int WIDTH      = 7,
  parameter int DIGITS     = 2,
  parameter int ACTIVE_LOW = 1,
  parameter int BLANK_LEAD = 0
)
(
  input logic                      i_Clk,
  input logic                      i_Rst,
  seven_segment_bcd_display_if.slave bus
);

  localparam int CW = $clog2(WIDTH + 1);
  localparam int BW = 4 * DIGITS;
  localparam int SW = 7 * DIGITS;
  localparam logic [63:0]   MAX_VAL  = max_value(DIGITS);
  localparam logic [CW-1:0] LAST_CNT = CW'(WIDTH - 1);

  function automatic logic [6:0] polarity(input logic [6:0] g);
    return (ACTIVE_LOW != 0) ? ~g : g;
  endfunction

  function automatic logic [SW-1:0] zero_pattern();
    logic [SW-1:0] p;
    p = '0;
    for (int k = 0; k < DIGITS; k++) begin
      p[7*k +: 7] = polarity((k == 0 || BLANK_LEAD == 0) ? SEG_0 : SEG_BLANK);
    end
    return p;
  endfunction

  localparam logic [SW-1:0] RESET_SEG = zero_pattern();

  state_e          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [WIDTH-1:0] bin_q, bin_d;
  logic [BW-1:0]   bcd_q, bcd_d;
  logic            ovf_pend_q, ovf_pend_d;
  logic            ovf_q, ovf_d;
  logic            busy_q, busy_d;
  logic            done_q, done_d;
  logic [SW-1:0]   seg_q, seg_d;

  logic [BW-1:0]   bcd_adj;
  logic [DIGITS-1:0] blank;
  logic [6:0]      glyph [DIGITS];
  logic [SW-1:0]   seg_next;

  always_comb begin
    bcd_adj = bcd_q;
    for (int k = 0; k < DIGITS; k++) begin
      if (bcd_q[4*k +: 4] >= 4'd5) begin
        bcd_adj[4*k +: 4] = bcd_q[4*k +: 4] + 4'd3;
      end
    end
  end

  // A digit blanks only while it and every digit above it are zero; digit 0 never blanks.
  always_comb begin
    logic lead;
    lead  = 1'b1;
    blank = '0;
    for (int k = DIGITS - 1; k >= 0; k--) begin
      lead     = lead && (bcd_q[4*k +: 4] == 4'd0);
      blank[k] = (BLANK_LEAD != 0) && (k != 0) && lead;
    end
  end

  for (genvar k = 0; k < DIGITS; k++) begin : g_digit
    seg7_glyph u_glyph (
      .i_Digit (bcd_q[4*k +: 4]),
      .i_Blank (blank[k]),
      .i_Dash  (ovf_pend_q),
      .o_Seg   (glyph[k])
    );
  end

  always_comb begin
    seg_next = '0;
    for (int k = 0; k < DIGITS; k++) begin
      seg_next[7*k +: 7] = polarity(glyph[k]);
    end
  end

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    bin_d      = bin_q;
    bcd_d      = bcd_q;
    ovf_pend_d = ovf_pend_q;
    ovf_d      = ovf_q;
    busy_d     = busy_q;
    done_d     = 1'b0;
    seg_d      = seg_q;
    case (state_q)
      IDLE: begin
        if (bus.i_Load && !busy_q) begin
          bin_d      = bus.i_Value;
          bcd_d      = '0;
          cnt_d      = '0;
          ovf_pend_d = 64'(bus.i_Value) > MAX_VAL;
          busy_d     = 1'b1;
          state_d    = SHIFT;
        end
      end
      SHIFT: begin
        bcd_d = {bcd_adj[BW-2:0], bin_q[WIDTH-1]};
        bin_d = bin_q << 1;
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == LAST_CNT) begin
          state_d = UPDATE;
        end
      end
      UPDATE: begin
        seg_d   = seg_next;
        ovf_d   = ovf_pend_q;
        done_d  = 1'b1;
        busy_d  = 1'b0;
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
        busy_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge i_Clk or posedge i_Rst) begin
    if (i_Rst) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      bin_q      <= '0;
      bcd_q      <= '0;
      ovf_pend_q <= 1'b0;
      ovf_q      <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      seg_q      <= RESET_SEG;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      bin_q      <= bin_d;
      bcd_q      <= bcd_d;
      ovf_pend_q <= ovf_pend_d;
      ovf_q      <= ovf_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      seg_q      <= seg_d;
    end
  end

  assign bus.o_Busy     = busy_q;
  assign bus.o_Done     = done_q;
  assign bus.o_Overflow = ovf_q;
  assign bus.o_Segments = seg_q;

endmodule

// File: tb/tb_seven_segment_bcd_display.sv
// Scoreboard bench for two display configurations: 7-bit/2-digit and 14-bit/4-digit blanked.
module tb_seven_segment_bcd_display;

  // Active-low glyphs {g,f,e,d,c,b,a}, written out by hand
  localparam logic [6:0] L0 = 7'b1000000;
  localparam logic [6:0] L1 = 7'b1111001;
  localparam logic [6:0] L2 = 7'b0100100;
  localparam logic [6:0] L4 = 7'b0011001;
  localparam logic [6:0] L5 = 7'b0010010;
  localparam logic [6:0] L7 = 7'b1111000;
  localparam logic [6:0] L9 = 7'b0010000;
  localparam logic [6:0] LB = 7'b1111111;
  localparam logic [6:0] LD = 7'b0111111;

  localparam logic [27:0] RST_A = {14'd0, L0, L0};
  localparam logic [27:0] RST_B = {LB, LB, LB, L0};

  typedef struct {
    logic [27:0] seg;
    logic        ovf;
  } exp_t;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  seven_segment_bcd_display_if #(.WIDTH(7),  .DIGITS(2)) a_if ();
  seven_segment_bcd_display_if #(.WIDTH(14), .DIGITS(4)) b_if ();

  seven_segment_bcd_display #(.WIDTH(7), .DIGITS(2), .ACTIVE_LOW(1), .BLANK_LEAD(0)) dut_a (
    .i_Clk (clk),
    .i_Rst (rst),
    .bus   (a_if.slave)
  );

  seven_segment_bcd_display #(.WIDTH(14), .DIGITS(4), .ACTIVE_LOW(1), .BLANK_LEAD(1)) dut_b (
    .i_Clk (clk),
    .i_Rst (rst),
    .bus   (b_if.slave)
  );

  int   checks = 0;
  int   fails  = 0;
  exp_t q_a[$];
  exp_t q_b[$];
  logic [27:0] last_exp [2];
  logic prev_done_a = 1'b0;
  logic prev_done_b = 1'b0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic flag(input string name);
    checks++;
    fails++;
    $display("FAIL %s (t=%0t)", name, $time);
  endtask

  // Monitors: pop one expectation per o_Done pulse
  initial begin : mon_a
    exp_t e;
    forever begin
      @(negedge clk);
      if (a_if.o_Done) begin
        check("a_done_single_cycle", prev_done_a, 0);
        check("a_busy_low_at_done", a_if.o_Busy, 0);
        if (q_a.size() == 0) flag("a_unexpected_done");
        else begin
          e = q_a.pop_front();
          check("a_segments", a_if.o_Segments, e.seg[13:0]);
          check("a_overflow", a_if.o_Overflow, e.ovf);
        end
      end
      prev_done_a = a_if.o_Done;
    end
  end

  initial begin : mon_b
    exp_t e;
    forever begin
      @(negedge clk);
      if (b_if.o_Done) begin
        check("b_done_single_cycle", prev_done_b, 0);
        check("b_busy_low_at_done", b_if.o_Busy, 0);
        if (q_b.size() == 0) flag("b_unexpected_done");
        else begin
          e = q_b.pop_front();
          check("b_segments", b_if.o_Segments, e.seg);
          check("b_overflow", b_if.o_Overflow, e.ovf);
        end
      end
      prev_done_b = b_if.o_Done;
    end
  end

  function automatic logic busy_of(input int which);
    return (which == 0) ? a_if.o_Busy : b_if.o_Busy;
  endfunction

  function automatic logic [27:0] seg_of(input int which);
    return (which == 0) ? {14'd0, a_if.o_Segments} : b_if.o_Segments;
  endfunction

  task automatic drive(input int which, input int v, input logic ld);
    if (which == 0) begin
      a_if.i_Value = 7'(v);
      a_if.i_Load  = ld;
    end else begin
      b_if.i_Value = 14'(v);
      b_if.i_Load  = ld;
    end
  endtask

  task automatic wait_idle(input int which);
    int n;
    n = 0;
    while (busy_of(which) && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (n >= 200) flag("wait_idle_timeout");
  endtask

  task automatic convert(input int which, input int v, input logic [27:0] seg,
                         input logic ovf, input string name);
    int   n;
    logic stable;
    exp_t e;
    wait_idle(which);
    @(posedge clk); #1;
    drive(which, v, 1'b1);
    e.seg = seg;
    e.ovf = ovf;
    if (which == 0) q_a.push_back(e);
    else            q_b.push_back(e);
    @(posedge clk); #1;
    drive(which, v, 1'b0);
    n      = 0;
    stable = 1'b1;
    while (n < 100) begin
      @(negedge clk);
      if (!busy_of(which)) break;
      n++;
      if (seg_of(which) !== last_exp[which]) stable = 1'b0;
    end
    check({name, "_busy_cycles"}, n, (which == 0) ? 8 : 15);
    check({name, "_held_while_busy"}, stable, 1);
    last_exp[which] = seg;
  endtask

  task automatic reset_checks(input string tag);
    check({tag, "_a_seg"},  a_if.o_Segments, RST_A[13:0]);
    check({tag, "_a_busy"}, a_if.o_Busy, 0);
    check({tag, "_a_done"}, a_if.o_Done, 0);
    check({tag, "_a_ovf"},  a_if.o_Overflow, 0);
    check({tag, "_b_seg"},  b_if.o_Segments, RST_B);
    check({tag, "_b_busy"}, b_if.o_Busy, 0);
  endtask

  task automatic pulse_reset(input string tag);
    @(posedge clk); #2;
    rst = 1'b1;
    @(negedge clk);
    reset_checks(tag);
    @(posedge clk); #1;
    rst = 1'b0;
    last_exp[0] = RST_A;
    last_exp[1] = RST_B;
  endtask

  initial begin
    exp_t e;
    rst = 1'b1;
    drive(0, 0, 1'b0);
    drive(1, 0, 1'b0);
    last_exp[0] = RST_A;
    last_exp[1] = RST_B;
    repeat (2) @(negedge clk);
    reset_checks("por");
    @(posedge clk); #1;
    rst = 1'b0;

    convert(0, 42,  {14'd0, L4, L2}, 1'b0, "a42");
    convert(0, 127, {14'd0, LD, LD}, 1'b1, "a127");
    convert(0, 5,   {14'd0, L0, L5}, 1'b0, "a5");
    convert(0, 100, {14'd0, LD, LD}, 1'b1, "a100");
    pulse_reset("idle_rst");
    convert(0, 0,   {14'd0, L0, L0}, 1'b0, "a0");

    convert(1, 7,     {LB, LB, LB, L7}, 1'b0, "b7");
    convert(1, 0,     {LB, LB, LB, L0}, 1'b0, "b0");
    convert(1, 9999,  {L9, L9, L9, L9}, 1'b0, "b9999");
    convert(1, 10000, {LD, LD, LD, LD}, 1'b1, "b10000");
    convert(1, 1005,  {L1, L0, L0, L5}, 1'b0, "b1005");
    convert(1, 50,    {LB, LB, L5, L0}, 1'b0, "b50");
    convert(1, 16383, {LD, LD, LD, LD}, 1'b1, "b16383");

    // Load held high with a new value each cycle: 20 is taken, then 29 (present in the o_Done cycle)
    wait_idle(0);
    e.ovf = 1'b0;
    e.seg = {14'd0, L2, L0};
    q_a.push_back(e);
    e.seg = {14'd0, L2, L9};
    q_a.push_back(e);
    for (int k = 0; k < 10; k++) begin
      @(posedge clk); #1;
      drive(0, 20 + k, 1'b1);
    end
    @(posedge clk); #1;
    drive(0, 0, 1'b0);
    @(negedge clk);
    wait_idle(0);
    last_exp[0] = {14'd0, L2, L9};

    // Reset part-way through converting 99: no o_Done, display returns to reset pattern
    @(posedge clk); #1;
    drive(0, 99, 1'b1);
    @(posedge clk); #1;
    drive(0, 99, 1'b0);
    repeat (3) @(posedge clk);
    #2 rst = 1'b1;
    @(negedge clk);
    reset_checks("mid_rst");
    @(posedge clk); #1;
    rst = 1'b0;
    last_exp[0] = RST_A;
    last_exp[1] = RST_B;
    repeat (3) @(negedge clk);
    check("mid_rst_a_seg_after", a_if.o_Segments, RST_A[13:0]);
    convert(0, 99, {14'd0, L9, L9}, 1'b0, "a99");

    repeat (5) @(negedge clk);
    check("a_queue_drained", q_a.size(), 0);
    check("b_queue_drained", q_b.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog_timeout: %0d checks, %0d failures", checks, fails);
    $fatal(1, "watchdog");
  end

endmodule
